// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the two-entry elastic pipeline register.
// State encoding, default bubble word and occupancy helper.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2,
        ST_BAD   = 2'd3
    } state_t;

    // Bubble words are all-zero (NOP-zero) by default.
    localparam logic NOP_BIT = 1'b0;

    function automatic logic [1:0] occ_of(input state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_nbit_reg_en.sv
// N-bit register with load enable and synchronous clear-to-value.
// Clear has priority over load.
module nbit_reg_en #(
    parameter int          N       = 32,
    parameter logic [N-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready.
// All outputs come straight from flops; no input-to-output path.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int           N      = 32,
    parameter logic [N-1:0] BUBBLE = {N{NOP_BIT}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    state_t       r_state;
    logic         r_out_valid;
    logic         r_in_ready;
    logic [1:0]   r_occ;

    state_t       w_state_nxt;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_main_en;
    logic         w_skid_en;
    logic         w_main_sel_skid;
    logic         w_clr;
    logic [N-1:0] w_main_d;
    logic [N-1:0] w_main_q;
    logic [N-1:0] w_skid_q;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_clr      = rst | flush;
    assign w_main_d   = w_main_sel_skid ? w_skid_q : in_data;

    always_comb begin
        w_state_nxt     = r_state;
        w_main_en       = 1'b0;
        w_skid_en       = 1'b0;
        w_main_sel_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_en   = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_en = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_en   = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_main_en       = 1'b1;
                    w_main_sel_skid = 1'b1;
                    w_state_nxt     = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Status outputs are registered from the next state so they are
    // available at the start of each cycle without decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_occ       <= occ_of(w_state_nxt);
        end
    end

    nbit_reg_en #(
        .N       (N),
        .CLR_VAL (BUBBLE)
    ) u_main (
        .clk   (clk),
        .i_clr (w_clr),
        .i_en  (w_main_en),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );

    nbit_reg_en #(
        .N       (N),
        .CLR_VAL (BUBBLE)
    ) u_skid (
        .clk   (clk),
        .i_clr (w_clr),
        .i_en  (w_skid_en),
        .i_d   (in_data),
        .o_q   (w_skid_q)
    );

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign occupancy = r_occ;
    assign out_data  = r_out_valid ? w_main_q : BUBBLE;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table then a random storm
// checked against a queue model of the two-entry buffer.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;

    int checks;
    int errors;

    logic [31:0] mdl_q[$];

    pipe_skid_reg #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle on the falling edge, advance the queue model on
    // the rising edge, leave time at posedge+1 for sampling.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] d, input logic ordy);
        logic ifire;
        logic ofire;
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        ifire = iv && (mdl_q.size() < 2);
        ofire = ordy && (mdl_q.size() > 0);
        @(posedge clk);
        if (r || f) begin
            mdl_q.delete();
        end else begin
            if (ofire) void'(mdl_q.pop_front());
            if (ifire) mdl_q.push_back(d);
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_d;
        exp_d = (mdl_q.size() > 0) ? mdl_q[0] : 32'h0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mdl_q.size() > 0));
        check({tag, ".out_data"}, out_data, exp_d);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(mdl_q.size() < 2));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(mdl_q.size()));
    endtask

    function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] d,
                                logic o, logic eov, logic [31:0] eod,
                                logic eir, logic [1:0] eocc);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.id = d; v.ordy = o;
        v.e_ov = eov; v.e_od = eod; v.e_ir = eir; v.e_occ = eocc;
        return v;
    endfunction

    initial begin
        logic        r;
        logic        f;
        logic        iv;
        logic        ordy;
        logic [31:0] d;
        logic        hold;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;

        // reset with traffic present
        vecs[0]  = mk(1, 0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 1, 0);
        vecs[1]  = mk(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,         1, 0, 32'h0, 1, 0);
        // streaming
        vecs[3]  = mk(0, 0, 1, 32'h1, 1, 1, 32'h1, 1, 1);
        vecs[4]  = mk(0, 0, 1, 32'h2, 1, 1, 32'h2, 1, 1);
        vecs[5]  = mk(0, 0, 1, 32'h3, 1, 1, 32'h3, 1, 1);
        vecs[6]  = mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0);
        // backpressure
        vecs[7]  = mk(0, 0, 1, 32'hA, 0, 1, 32'hA, 1, 1);
        vecs[8]  = mk(0, 0, 1, 32'hB, 0, 1, 32'hA, 0, 2);
        vecs[9]  = mk(0, 0, 1, 32'hB, 0, 1, 32'hA, 0, 2);
        vecs[10] = mk(0, 0, 0, 32'h0, 1, 1, 32'hB, 1, 1);
        vecs[11] = mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0);
        // simultaneous in/out fire in ONE
        vecs[12] = mk(0, 0, 1, 32'h5, 0, 1, 32'h5, 1, 1);
        vecs[13] = mk(0, 0, 1, 32'h6, 1, 1, 32'h6, 1, 1);
        vecs[14] = mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 0);
        // flush while full with a word offered
        vecs[15] = mk(0, 0, 1, 32'h7, 0, 1, 32'h7, 1, 1);
        vecs[16] = mk(0, 0, 1, 32'h8, 0, 1, 32'h7, 0, 2);
        vecs[17] = mk(0, 1, 1, 32'hC, 0, 0, 32'h0, 1, 0);
        vecs[18] = mk(0, 0, 0, 32'hC, 1, 0, 32'h0, 1, 0);
        // rst and flush together
        vecs[19] = mk(1, 1, 1, 32'h9, 1, 0, 32'h0, 1, 0);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].id,
                  vecs[i].ordy);
            check($sformatf("v%0d.out_valid", i), 32'(out_valid),
                  32'(vecs[i].e_ov));
            check($sformatf("v%0d.out_data", i), out_data, vecs[i].e_od);
            check($sformatf("v%0d.in_ready", i), 32'(in_ready),
                  32'(vecs[i].e_ir));
            check($sformatf("v%0d.occupancy", i), 32'(occupancy),
                  32'(vecs[i].e_occ));
        end

        // hand sequence: rst+flush in the middle of a full buffer
        cycle(0, 0, 1, 32'h11, 0);
        cycle(0, 0, 1, 32'h22, 0);
        check_model("full_pre");
        cycle(1, 1, 1, 32'h33, 1);
        check_model("rstflush");
        check("rstflush.occ0", 32'(occupancy), 32'h0);

        // random storm; upstream holds a refused word until accepted
        hold = 1'b0;
        iv   = 1'b0;
        d    = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 63) == 0);
            f    = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                iv = ($urandom_range(0, 3) != 0);
                d  = $urandom;
            end
            hold = iv && (mdl_q.size() >= 2);
            cycle(r, f, iv, d, ordy);
            if (r || f) hold = 1'b0;
            check_model($sformatf("rnd%0d", n));
        end

        // drain so every held word is observed leaving in order
        for (int n = 0; n < 4; n++) begin
            cycle(0, 0, 0, 32'h0, 1);
            check_model($sformatf("drain%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
